// File: rtl/reg_file_pkg.sv
// Shared defaults for the scoreboarded register file datapath.
// The top module and the pending table both import these values.
package reg_file_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_ZERO_REG = 1;
    localparam int DEF_BYPASS   = 1;

endpackage : reg_file_pkg

// File: rtl/sb_pending_table.sv
// Per-register pending bits for in-flight producers.
// Also tracks the number of pending registers and flags a reserve of an already-pending register.
module sb_pending_table
    import reg_file_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = DEF_ZERO_REG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reserve,
    input  logic [ADDR_W-1:0] reserve_no,
    input  logic              clear,
    input  logic [ADDR_W-1:0] clear_no,
    input  logic [ADDR_W-1:0] lookup1_no,
    input  logic [ADDR_W-1:0] lookup2_no,
    output logic              pending1,
    output logic              pending2,
    output logic              waw_hazard,
    output logic [ADDR_W:0]   pending_count
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DEPTH-1:0] pending_q, pending_d;
    logic [ADDR_W:0]  count_q, count_d;
    logic             reserve_ok, clear_ok, same_reg;

    assign reserve_ok = reserve && !((ZERO_REG != 0) && (reserve_no == '0));
    assign clear_ok   = clear && !((ZERO_REG != 0) && (clear_no == '0));
    assign same_reg   = reserve_ok && (reserve_no == clear_no);

    // Reserve is applied after the clear so a new producer wins over a retiring one.
    always_comb begin
        pending_d = pending_q;
        count_d   = count_q;
        if (clear_ok) begin
            pending_d[clear_no] = 1'b0;
        end
        if (reserve_ok) begin
            pending_d[reserve_no] = 1'b1;
        end
        if (reserve_ok && !pending_q[reserve_no]) begin
            count_d = count_d + ONE;
        end
        if (clear_ok && pending_q[clear_no] && !same_reg) begin
            count_d = count_d - ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    assign pending1      = pending_q[lookup1_no];
    assign pending2      = pending_q[lookup2_no];
    assign waw_hazard    = reserve_ok && pending_q[reserve_no];
    assign pending_count = count_q;

endmodule : sb_pending_table

// File: rtl/reg_file_sb.sv
// Parametrised register file with two combinational read ports, one write port,
// optional hardwired zero register, optional write-to-read bypass and a pending scoreboard.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int BYPASS   = DEF_BYPASS
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteRegNo,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    input  logic              Reserve,
    input  logic [ADDR_W-1:0] ReserveRegNo,
    output logic              Ready1,
    output logic              Ready2,
    output logic              WawHazard,
    output logic [ADDR_W:0]   PendingCount
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic              write_ok;
    logic              bypass1, bypass2, zero1, zero2;
    logic              pending1, pending2;

    assign write_ok = RegWrite && !((ZERO_REG != 0) && (WriteRegNo == '0));

    always_comb begin
        regs_d = regs_q;
        if (write_ok) begin
            regs_d[WriteRegNo] = WriteData;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    sb_pending_table #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_pending (
        .clk           (Clock),
        .rst           (Reset),
        .reserve       (Reserve),
        .reserve_no    (ReserveRegNo),
        .clear         (RegWrite),
        .clear_no      (WriteRegNo),
        .lookup1_no    (ReadReg1),
        .lookup2_no    (ReadReg2),
        .pending1      (pending1),
        .pending2      (pending2),
        .waw_hazard    (WawHazard),
        .pending_count (PendingCount)
    );

    assign bypass1 = (BYPASS != 0) && write_ok && (WriteRegNo == ReadReg1);
    assign bypass2 = (BYPASS != 0) && write_ok && (WriteRegNo == ReadReg2);
    assign zero1   = (ZERO_REG != 0) && (ReadReg1 == '0);
    assign zero2   = (ZERO_REG != 0) && (ReadReg2 == '0);

    // Reset and the zero register override the bypass so nothing leaks through while held.
    always_comb begin
        ReadData1 = regs_q[ReadReg1];
        Ready1    = ~pending1;
        if (bypass1) begin
            ReadData1 = WriteData;
            Ready1    = 1'b1;
        end
        if (zero1 || Reset) begin
            ReadData1 = '0;
            Ready1    = 1'b1;
        end
    end

    always_comb begin
        ReadData2 = regs_q[ReadReg2];
        Ready2    = ~pending2;
        if (bypass2) begin
            ReadData2 = WriteData;
            Ready2    = 1'b1;
        end
        if (zero2 || Reset) begin
            ReadData2 = '0;
            Ready2    = 1'b1;
        end
    end

endmodule : reg_file_sb
